// File: rtl/frame_gen_seq.sv
// Ethernet test-frame generator: header, sequence number, launch timestamp
// and byte-index padding, streamed to the MAC TX byte interface.
module frame_gen_seq #(
    parameter int unsigned FRAME_LEN  = 60,
    parameter int unsigned IFG_CYCLES = 100,
    parameter int unsigned NUM_FRAMES = 0,
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = 48'h004e46324300,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        conf_tx_en,
    output logic        conf_tx_jumbo_en,
    output logic        conf_tx_no_gen_crc,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic        busy,
    output logic [31:0] frames_sent
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        SEND,
        GAP
    } state_t;

    localparam logic [10:0] LAST_IDX = 11'(FRAME_LEN - 1);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [31:0] RUN_LEN  = 32'(NUM_FRAMES);

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] run_q, run_d;
    logic        stop_q, stop_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] lts_q, lts_d;
    logic [31:0] sent_q, sent_d;
    logic [31:0] ts_q;
    logic [7:0]  data_q, data_d;
    logic        dvld_q, dvld_d;
    logic        busy_q;
    logic        en_q;

    logic [175:0] hdr;
    logic [7:0]   hdr_b [32];
    logic [7:0]   byte_d;

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            run_q   <= '0;
            stop_q  <= 1'b0;
            seq_q   <= '0;
            lts_q   <= '0;
            sent_q  <= '0;
            ts_q    <= '0;
            data_q  <= '0;
            dvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            stop_q  <= stop_d;
            seq_q   <= seq_d;
            lts_q   <= lts_d;
            sent_q  <= sent_d;
            ts_q    <= ts_q + 32'd1;
            data_q  <= data_d;
            dvld_q  <= dvld_d;
            busy_q  <= (state_d != IDLE);
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        run_d   = run_q;
        stop_d  = stop_q | stop;
        seq_d   = seq_q;
        lts_d   = lts_q;
        sent_d  = sent_q;
        unique case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start && !stop) begin
                    state_d = WAIT_ACK;
                    idx_d   = '0;
                    run_d   = '0;
                end
            end
            WAIT_ACK: begin
                idx_d = '0;
                if (mac_tx_ack) begin
                    state_d = SEND;
                    idx_d   = 11'd1;
                    lts_d   = ts_q;
                end
            end
            SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = GAP;
                    gap_d   = '0;
                    sent_d  = sent_q + 32'd1;
                    seq_d   = seq_q + 32'd1;
                    run_d   = run_q + 32'd1;
                end else begin
                    idx_d = idx_q + 11'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    idx_d = '0;
                    // a stop seen on this very cycle still ends the run
                    if (stop_d || (RUN_LEN != 0 && run_q == RUN_LEN)) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // bytes 0..21 come from the header; 22..31 fall back to their index
    always_comb begin
        hdr = {DST_MAC, SRC_MAC, ETH_TYPE, seq_q, lts_q};
        for (int k = 0; k < 22; k++) begin
            hdr_b[k] = hdr[8*(21-k) +: 8];
        end
        for (int k = 22; k < 32; k++) begin
            hdr_b[k] = 8'(k);
        end
    end

    always_comb begin
        byte_d = idx_d[7:0];
        if (idx_d < 11'd32) begin
            byte_d = hdr_b[idx_d[4:0]];
        end
        dvld_d = (state_d == WAIT_ACK) || (state_d == SEND);
        data_d = dvld_d ? byte_d : 8'h00;
    end

    assign conf_tx_en         = en_q;
    assign conf_tx_jumbo_en   = 1'b0;
    assign conf_tx_no_gen_crc = 1'b0;
    assign mac_tx_data        = data_q;
    assign mac_tx_dvld        = dvld_q;
    assign busy               = busy_q;
    assign frames_sent        = sent_q;

endmodule

// File: tb/tb_frame_gen_seq.sv
// Random start/stop/ack/reset traffic on three generator configurations,
// compared cycle by cycle against a frame-level reference model.
module tb_frame_gen_seq;

    localparam int N    = 3;
    localparam int NCYC = 20000;
    localparam int FL  [N] = '{60, 60, 1514};
    localparam int IFG [N] = '{100, 100, 1};
    localparam int NF  [N] = '{1, 0, 3};
    localparam int SDIV[N] = '{2000, 300, 3000};
    localparam logic [47:0] DST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC = 48'h004e46324300;
    localparam logic [15:0] ETH = 16'h88B5;

    logic clk = 1'b0;
    logic [N-1:0] rst_r, start_r, stop_r, ack_r;
    logic [N-1:0] en_w, jumbo_w, nocrc_w, dvld_w, busy_w;
    logic [7:0]   data_w [N];
    logic [31:0]  sent_w [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        frame_gen_seq #(
            .FRAME_LEN (FL[g]),
            .IFG_CYCLES(IFG[g]),
            .NUM_FRAMES(NF[g])
        ) u_dut (
            .tx_clk            (clk),
            .reset             (rst_r[g]),
            .start             (start_r[g]),
            .stop              (stop_r[g]),
            .conf_tx_en        (en_w[g]),
            .conf_tx_jumbo_en  (jumbo_w[g]),
            .conf_tx_no_gen_crc(nocrc_w[g]),
            .mac_tx_data       (data_w[g]),
            .mac_tx_dvld       (dvld_w[g]),
            .mac_tx_ack        (ack_r[g]),
            .busy              (busy_w[g]),
            .frames_sent       (sent_w[g])
        );
    end

    // reference model: run/frame/gap bookkeeping in plain counters
    bit          m_busy [N];
    bit          m_on   [N];
    bit          m_ackd [N];
    bit          m_stop [N];
    bit          m_en   [N];
    int          m_idx  [N];
    int          m_gap  [N];
    int          m_run  [N];
    logic [31:0] m_seq  [N];
    logic [31:0] m_sent [N];
    logic [31:0] m_ts   [N];
    logic [31:0] m_lts  [N];
    bit          ack_hold [N];

    function automatic logic [7:0] exp_byte(int idx, logic [31:0] sq,
                                            logic [31:0] lt);
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] e;
        d = DST;
        s = SRC;
        e = ETH;
        if (idx < 6)  return d[8*(5-idx) +: 8];
        if (idx < 12) return s[8*(11-idx) +: 8];
        if (idx < 14) return e[8*(13-idx) +: 8];
        if (idx < 18) return sq[8*(17-idx) +: 8];
        if (idx < 22) return lt[8*(21-idx) +: 8];
        return 8'(idx % 256);
    endfunction

    always @(posedge clk) begin
        logic [31:0] ts_now;
        for (int i = 0; i < N; i++) begin
            if (rst_r[i]) begin
                m_busy[i] = 0; m_on[i] = 0; m_ackd[i] = 0;
                m_stop[i] = 0; m_en[i] = 0;
                m_idx[i] = 0; m_gap[i] = 0; m_run[i] = 0;
                m_seq[i] = 0; m_sent[i] = 0; m_ts[i] = 0; m_lts[i] = 0;
            end else begin
                ts_now   = m_ts[i];
                m_ts[i]  = m_ts[i] + 1;
                m_en[i]  = 1;
                if (!m_busy[i]) begin
                    m_stop[i] = 0;
                    if (start_r[i] && !stop_r[i]) begin
                        m_busy[i] = 1; m_on[i] = 1; m_ackd[i] = 0;
                        m_idx[i] = 0; m_run[i] = 0;
                    end
                end else begin
                    if (stop_r[i]) m_stop[i] = 1;
                    if (m_on[i]) begin
                        if (!m_ackd[i]) begin
                            if (ack_r[i]) begin
                                m_ackd[i] = 1; m_lts[i] = ts_now; m_idx[i] = 1;
                            end
                        end else if (m_idx[i] == FL[i] - 1) begin
                            m_on[i] = 0;
                            m_sent[i] = m_sent[i] + 1;
                            m_seq[i] = m_seq[i] + 1;
                            m_run[i]++;
                            m_gap[i] = IFG[i];
                        end else begin
                            m_idx[i]++;
                        end
                    end else begin
                        m_gap[i]--;
                        if (m_gap[i] == 0) begin
                            if (m_stop[i] || (NF[i] != 0 && m_run[i] == NF[i])) begin
                                m_busy[i] = 0; m_stop[i] = 0;
                            end else begin
                                m_on[i] = 1; m_ackd[i] = 0; m_idx[i] = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got=%h exp=%h", tag, inst, $time, got, exp);
        end
    endtask

    initial begin
        rst_r   = '1;
        start_r = '0;
        stop_r  = '0;
        ack_r   = '0;
        for (int i = 0; i < N; i++) ack_hold[i] = (i == 0);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                for (int i = 0; i < N; i++) begin
                    check("dvld", i, 32'(dvld_w[i]), 32'(m_on[i]));
                    check("data", i, 32'(data_w[i]),
                          m_on[i] ? 32'(exp_byte(m_idx[i], m_seq[i], m_lts[i])) : 32'h0);
                    check("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
                    check("frames_sent", i, sent_w[i], m_sent[i]);
                    check("tx_en", i, 32'(en_w[i]), 32'(m_en[i]));
                    check("jumbo", i, 32'(jumbo_w[i]), 32'h0);
                    check("no_crc", i, 32'(nocrc_w[i]), 32'h0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (c < 2) begin
                    rst_r[i] = 1'b1;
                    start_r[i] = 1'b0; stop_r[i] = 1'b0; ack_r[i] = 1'b0;
                end else if (c < 14) begin
                    rst_r[i] = 1'b0;
                    start_r[i] = 1'b0; stop_r[i] = 1'b0; ack_r[i] = 1'b0;
                end else begin
                    rst_r[i]   = ($urandom_range(0, 3999) == 0);
                    start_r[i] = ($urandom_range(0, 29) == 0);
                    stop_r[i]  = ($urandom_range(0, SDIV[i]) == 0);
                    if (start_r[i] && $urandom_range(0, 3) == 0) stop_r[i] = 1'b1;
                    if ($urandom_range(0, 999) == 0) ack_hold[i] = !ack_hold[i];
                    ack_r[i] = ack_hold[i] ? 1'b1 : ($urandom_range(0, 5) == 0);
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
